iob_cpu_bus_arbiter: RTL
========================

Name: iob_cpu_bus_arbiter

Overview:
- Shares one IOb-native memory port between the CPU instruction bus (master 0) and data bus (master 1).
- Sits between the CPU wrapper's ibus/dbus and the system interconnect or internal memory.
- One outstanding transaction at a time. Selectable round-robin or fixed data-priority arbitration.
- A watchdog aborts transactions whose slave never responds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
PRIO, 0, 0 = round-robin, 1 = fixed priority to dbus
TIMEOUT_W, 10, watchdog counter width; 0 disables the watchdog
TIMEOUT_RDATA, 32'hDEADBEEF, read data returned on an aborted transaction

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
ibus_valid  in  1  instruction request, held until ibus_ready
ibus_addr  in  ADDR_W  instruction address
ibus_rdata  out  DATA_W  instruction read data
ibus_ready  out  1  one-cycle response pulse
dbus_valid  in  1  data request, held until dbus_ready
dbus_addr  in  ADDR_W  data address
dbus_wdata  in  DATA_W  write data
dbus_wstrb  in  DATA_W/8  byte strobes; 0 = read
dbus_rdata  out  DATA_W  data read data
dbus_ready  out  1  one-cycle response pulse
mem_valid  out  1  shared request valid
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data; 0 for ibus
mem_wstrb  out  DATA_W/8  registered strobes; 0 for ibus
mem_rdata  in  DATA_W  slave read data
mem_ready  in  1  slave response pulse
err  out  1  sticky watchdog-abort flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; mem_valid, mem_addr, mem_wdata, mem_wstrb, ibus_ready, dbus_ready and err are 0.
  - gnt_last=0 (ibus); watchdog count=0.
  - ibus_rdata and dbus_rdata follow mem_rdata.
- States:
  - IDLE: no transaction.
  - BUSY: mem_valid=1; payload registers stable; gnt holds the served master.
- Arbitration. Eligible set = masters with valid=1, minus the master whose ready is pulsing this cycle (its valid is stale).
  - PRIO=0: on a tie, grant the master != gnt_last.
  - PRIO=1: dbus always wins a tie.
  - gnt_last updates on every grant.
- IDLE -> BUSY: when the eligible set is non-empty, latch addr/wdata/wstrb of the winner and set gnt. mem_valid rises next cycle (request at cycle N -> mem_valid at N+1).
- BUSY, mem_ready=1:
  - Drive ready of gnt combinationally the same cycle; rdata = mem_rdata.
  - If the other master is eligible, go BUSY->BUSY with its payload latched; mem_valid stays 1 and the new request is presented at N+1.
  - Otherwise go to IDLE; mem_valid=0 at N+1.
- BUSY, mem_ready=0: hold every registered output; watchdog count increments.
- Watchdog (TIMEOUT_W>0):
  - Count resets on entry to BUSY, including BUSY->BUSY.
  - When count reaches 2^TIMEOUT_W-1 with mem_ready=0: pulse ready of gnt with rdata=TIMEOUT_RDATA, set err=1 (sticky until reset), drop mem_valid next cycle, go to IDLE. No re-arbitration in the abort cycle.
- mem_ready in IDLE is ignored; no ready pulses to either master.
- mem_ready and timeout in the same cycle: mem_ready wins; normal completion, no err.
- Address, data and strobes pass through unmodified; no boot remapping in this block.
- Reset mid-BUSY: mem_valid drops immediately. After reset release, any still-held valid is re-arbitrated from IDLE.

Decomposition:
- Shared package (iob_cpu_bus_arb_pkg): state encoding (IDLE=0, BUSY=1), master IDs (IBUS=0, DBUS=1), TIMEOUT_RDATA default.
- Sub-module iob_rr_arb2: combinational 2-way arbiter.
  - Inputs: req[1:0], gnt_last, prio_mode.
  - Outputs: one-hot gnt and the winning index.
  - Reusable by other two-master shares.

Test Plan:
- Single ibus read at addr 0x100, mem_ready two cycles after mem_valid with rdata 0x00000013 -> mem_valid at N+1, mem_addr=0x100, mem_wstrb=0, ibus_ready single pulse, ibus_rdata=0x13, dbus_ready=0.
- PRIO=0, ibus and dbus valid together right after reset -> dbus served first. In its ready cycle ibus is granted BUSY->BUSY, mem_valid stays high continuously, gnt_last toggles each grant.
- PRIO=1, dbus re-requests every cycle with ibus pending -> dbus wins every tie, ibus granted only in a cycle where dbus is ineligible.
- dbus write addr 0x22, wdata 0xA5A5A5A5, wstrb 0x3 -> mem_* carry exactly those values. Changing dbus inputs while BUSY does not alter mem_*.
- mem_ready never asserted on a dbus read, TIMEOUT_W=10 -> after 1023 BUSY cycles dbus_ready pulses with rdata 0xDEADBEEF, err=1 persists, mem_valid=0 next cycle. Also: mem_ready on the exact timeout cycle leaves err=0.
- rst asserted mid-BUSY -> mem_valid=0 in the same cycle without a clock edge, err cleared. After release with ibus_valid held, ibus is re-granted and completes normally.

Source files
------------

// File: rtl/iob_cpu_bus_arb_pkg.sv
// iob_cpu_bus_arb_pkg: shared state encoding, master IDs and abort read data for the CPU bus arbiter
package iob_cpu_bus_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam logic IBUS = 1'b0;
  localparam logic DBUS = 1'b1;
  localparam logic [31:0] TIMEOUT_RDATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/iob_rr_arb2.sv
// iob_rr_arb2: combinational two-way arbiter, round-robin or fixed priority to requester 1
module iob_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       gnt_last_i,
  input  logic       prio_mode_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);
  // on a tie pick requester 1 in priority mode, otherwise the one not served last
  always_comb begin
    idx_o = &req_i ? (prio_mode_i | ~gnt_last_i) : req_i[1];
    gnt_o = |req_i ? (idx_o ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// iob_cpu_bus_arbiter: shares one IOb memory port between CPU ibus and dbus with a watchdog
module iob_cpu_bus_arbiter
  import iob_cpu_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PRIO = 0,
  parameter int TIMEOUT_W = 10,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(TIMEOUT_RDATA_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus_valid,
  input  logic [ADDR_W-1:0]   ibus_addr,
  output logic [DATA_W-1:0]   ibus_rdata,
  output logic                ibus_ready,
  input  logic                dbus_valid,
  input  logic [ADDR_W-1:0]   dbus_addr,
  input  logic [DATA_W-1:0]   dbus_wdata,
  input  logic [DATA_W/8-1:0] dbus_wstrb,
  output logic [DATA_W-1:0]   dbus_rdata,
  output logic                dbus_ready,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                err
);
  localparam int CW = TIMEOUT_W > 0 ? TIMEOUT_W : 1;
  localparam int SW = DATA_W / 8;
  state_t            state_q, state_d;
  logic              gnt_q, gnt_d, gnt_last_q, gnt_last_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy, done, abort, resp, grant, win;
  logic [1:0]        req, arb_gnt;
  iob_rr_arb2 u_arb (
    .req_i       (req),
    .gnt_last_i  (gnt_last_q),
    .prio_mode_i (PRIO != 0),
    .gnt_o       (arb_gnt),
    .idx_o       (win)
  );
  // response decode; a master whose ready pulses this cycle holds a stale valid and is not eligible
  always_comb begin
    busy       = state_q == BUSY;
    done       = busy & mem_ready;
    abort      = busy & ~mem_ready & (TIMEOUT_W > 0) & (&cnt_q);
    resp       = done | abort;
    ibus_ready = resp & (gnt_q == IBUS);
    dbus_ready = resp & (gnt_q == DBUS);
    ibus_rdata = abort ? TIMEOUT_RDATA : mem_rdata;
    dbus_rdata = abort ? TIMEOUT_RDATA : mem_rdata;
    req        = {dbus_valid & ~dbus_ready, ibus_valid & ~ibus_ready};
    grant      = (~busy | done) & (|arb_gnt);
    mem_valid  = busy;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_wstrb  = wstrb_q;
    err        = err_q;
  end
  // next state: latch the winner on grant, retire on response, otherwise age the watchdog
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_last_d = gnt_last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = busy ? cnt_q + 1'b1 : cnt_q;
    err_d      = err_q | abort;
    if (grant) begin
      state_d    = BUSY;
      gnt_d      = win;
      gnt_last_d = win;
      addr_d     = win ? dbus_addr : ibus_addr;
      wdata_d    = win ? dbus_wdata : '0;
      wstrb_d    = win ? dbus_wstrb : '0;
      cnt_d      = '0;
    end else if (resp) begin
      state_d = IDLE;
    end
  end
  // state and payload registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= IBUS;
      gnt_last_q <= IBUS;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_last_q <= gnt_last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end
endmodule
